// File: rtl/csa_accumulator.sv
// Streaming multi-operand adder: 3:2 carry-save fold per accepted operand, segmented CPA resolve on last.
// Latency: last operand accepted at edge N -> out_valid after edge N+CPA_STAGES.
// Backpressure: in_ready low while resolving/holding a result; out_sum held until out_ready.
module csa_accumulator #(
    parameter int WIDTH      = 32,
    parameter int CPA_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             busy
);

    localparam int SEG  = WIDTH / CPA_STAGES;
    localparam int SEGW = (CPA_STAGES > 1) ? $clog2(CPA_STAGES) : 1;
    localparam logic [SEGW-1:0] SEG_LAST = SEGW'(CPA_STAGES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        RESOLVE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] carry_r;
    logic [WIDTH-1:0] c_sh;
    logic [WIDTH-1:0] out_sum_r;
    logic [SEGW-1:0]  seg;
    logic             cin;
    logic             accept;
    logic             unload;
    logic [SEG-1:0]   seg_a;
    logic [SEG-1:0]   seg_b;
    logic [SEG:0]     seg_add;

    // Carry vector is weighted one bit up; the MSB carry falls off (mod 2^WIDTH).
    assign c_sh    = {carry_r[WIDTH-2:0], 1'b0};
    assign seg_a   = sum_r[int'(seg)*SEG +: SEG];
    assign seg_b   = c_sh[int'(seg)*SEG +: SEG];
    assign seg_add = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, cin};
    assign out_sum = out_sum_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        unload    = 1'b0;
        case (state)
            IDLE, ACCUM: begin
                in_ready = 1'b1;
                busy     = (state != IDLE);
                accept   = in_valid;
                if (in_valid) begin
                    state_nxt = in_last ? RESOLVE : ACCUM;
                end
            end
            RESOLVE: begin
                if (seg == SEG_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                unload    = out_ready;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r     <= '0;
            carry_r   <= '0;
            out_sum_r <= '0;
            seg       <= '0;
            cin       <= 1'b0;
        end else begin
            if (accept) begin
                sum_r   <= sum_r ^ c_sh ^ in_data;
                carry_r <= (sum_r & c_sh) | (sum_r & in_data) | (c_sh & in_data);
                if (in_last) begin
                    seg <= '0;
                    cin <= 1'b0;
                end
            end
            if (state == RESOLVE) begin
                out_sum_r[int'(seg)*SEG +: SEG] <= seg_add[SEG-1:0];
                cin <= seg_add[SEG];
                seg <= (seg == SEG_LAST) ? '0 : seg + 1'b1;
            end
            if (unload) begin
                sum_r   <= '0;
                carry_r <= '0;
            end
        end
    end

endmodule
